// File: rtl/pipeline_skid_register_pkg.sv
// Shared definitions for the elastic pipeline stage register: poison fill,
// skid-buffer state encoding and the reference clock period.
package pipeline_skid_register_pkg;

  localparam logic [31:0] POISON_WORD = 32'h2A2A_2A2A;

  // Widest payload the poison fill can cover; FLUSH_VALUE is a slice of it.
  localparam int unsigned POISON_FILL_WIDTH = 1024;
  localparam logic [POISON_FILL_WIDTH-1:0] POISON_FILL = {32{POISON_WORD}};

  localparam int unsigned CLOCK_PERIOD = 10;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/pipeline_skid_register.sv
// Elastic stage register with a 2-entry skid buffer, registered In_Ready and
// synchronous flush. Define PIPE_PERF_EN to add stall/flush perf counters.
module pipeline_skid_register
  import pipeline_skid_register_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH      = 64,
  parameter logic [DATA_WIDTH-1:0] FLUSH_VALUE     = POISON_FILL[DATA_WIDTH-1:0],
  parameter int unsigned           STALL_CNT_WIDTH = 32
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       Flush,
  input  logic                       In_Valid,
  output logic                       In_Ready,
  input  logic [DATA_WIDTH-1:0]      In_Data,
  output logic                       Out_Valid,
  input  logic                       Out_Ready,
  output logic [DATA_WIDTH-1:0]      Out_Data,
`ifdef PIPE_PERF_EN
  output logic [STALL_CNT_WIDTH-1:0] Stall_Count,
  output logic [15:0]                Flush_Count,
`endif
  output skid_state_t                dbg_state
);

  // Handshake: a beat transfers on a rising edge where valid and ready are
  // both high; a producer holding valid must keep data stable until ready.
  // In_Ready depends only on the state register, never on Out_Ready.

  if (DATA_WIDTH < 1 || DATA_WIDTH > POISON_FILL_WIDTH || STALL_CNT_WIDTH < 1) begin : g_bad_cfg
    $error("pipeline_skid_register: unsupported DATA_WIDTH or STALL_CNT_WIDTH");
  end

  skid_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  in_fire, out_fire;

  assign in_fire  = In_Valid & In_Ready;
  assign out_fire = Out_Valid & Out_Ready;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= EMPTY;
      main_q  <= FLUSH_VALUE;
      skid_q  <= FLUSH_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (Flush) begin
      state_d = EMPTY;
      main_d  = FLUSH_VALUE;
      skid_d  = FLUSH_VALUE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = BUSY;
            main_d  = In_Data;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_d = In_Data;
          end else if (in_fire) begin
            state_d = FULL;
            skid_d  = In_Data;
          end else if (out_fire) begin
            state_d = EMPTY;
            main_d  = FLUSH_VALUE;
          end
        end
        FULL: begin
          // The skid entry moves up before anything new is accepted.
          if (out_fire) begin
            state_d = BUSY;
            main_d  = skid_q;
            skid_d  = FLUSH_VALUE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = FLUSH_VALUE;
          skid_d  = FLUSH_VALUE;
        end
      endcase
    end
  end

  always_comb begin
    Out_Valid = (state_q != EMPTY);
    In_Ready  = (state_q != FULL);
  end

  assign Out_Data  = main_q;
  assign dbg_state = state_q;

`ifdef PIPE_PERF_EN
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_q;
  logic [15:0]                flush_cnt_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (Out_Valid && !Out_Ready && !Flush && !(&stall_cnt_q))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      // Only a flush that kills a live beat counts.
      if (Flush && Out_Valid && !(&flush_cnt_q))
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign Stall_Count = stall_cnt_q;
  assign Flush_Count = flush_cnt_q;
`endif

endmodule

// File: doc/pipeline_skid_register.md
Name: pipeline_skid_register

Overview:
- Parametrised, elastic successor to the fixed per-stage pipeline registers.
- Carries an arbitrary-width payload bundle between two stages with valid/ready handshaking.
- A 2-entry skid buffer sustains one transfer per cycle with registered In_Ready, so there is no combinational ready path across stages.
- Supports synchronous flush (bubble insertion with a poison fill). Intended for any stage boundary (F/D, D/E, E/M, M/W).

Parameters:
- DATA_WIDTH, 64, payload width in bits (e.g. PC + PC+4 bundle).
- FLUSH_VALUE, {2{POISON_WORD}}, value loaded into the data registers on reset and flush. DATA_WIDTH bits, truncated or replicated from POISON_WORD.
- STALL_CNT_WIDTH, 32, width of the perf stall counter (used only with the optional feature).

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  synchronous reset, active-low.
- Flush  in  1  synchronous flush; discards all held and incoming data.
- In_Valid  in  1  upstream has data.
- In_Ready  out  1  register can accept data; registered output.
- In_Data  in  DATA_WIDTH  upstream payload.
- Out_Valid  out  1  payload available downstream.
- Out_Ready  in  1  downstream accepts this cycle; low means stall.
- Out_Data  out  DATA_WIDTH  payload, driven from the main register.
- Stall_Count  out  STALL_CNT_WIDTH  only with PIPE_PERF_EN.
- Flush_Count  out  16  only with PIPE_PERF_EN.

Behaviour:
- Handshake events: in_fire = In_Valid & In_Ready; out_fire = Out_Valid & Out_Ready.
- Upstream must hold In_Data stable while In_Valid=1 and In_Ready=0.
- Priority order: RST_N=0, then Flush, then normal operation.
- Reset, on a clock edge with RST_N=0:
  - state <= EMPTY; main and skid registers <= FLUSH_VALUE.
  - Out_Valid=0, In_Ready=1, Out_Data=FLUSH_VALUE, counters=0.
  - Applies mid-transfer; any held data is lost.
- States and transitions:
  - EMPTY: in_fire -> BUSY, main<=In_Data.
  - BUSY:
    - in_fire & out_fire -> BUSY, main<=In_Data.
    - in_fire & !out_fire -> FULL, skid<=In_Data.
    - !in_fire & out_fire -> EMPTY, main<=FLUSH_VALUE.
    - otherwise hold.
  - FULL: out_fire -> BUSY, main<=skid, skid<=FLUSH_VALUE. Otherwise hold. In_Ready=0, so no in_fire is possible.
- Output decodes: Out_Valid = (state != EMPTY). In_Ready = (state != FULL), taken from a state register, never from Out_Ready.
- Latency: 1 cycle from in_fire to Out_Valid when EMPTY.
- Throughput: 1 transfer per cycle while Out_Ready=1.
- Flush (RST_N=1, Flush=1):
  - Next state EMPTY; main and skid <= FLUSH_VALUE.
  - A same-cycle in_fire is discarded, and a same-cycle out_fire is still counted as consumed by downstream.
  - Next cycle: Out_Valid=0, In_Ready=1.
- Ordering: data leaves in arrival order; the skid entry is never overtaken.
- Illegal state encoding recovers to EMPTY.

Optional Feature:
- Macro PIPE_PERF_EN.
- Defined:
  - Stall_Count increments each cycle with Out_Valid & !Out_Ready & !Flush, saturating at all-ones.
  - Flush_Count increments each cycle with Flush=1 and Out_Valid=1 (i.e. a real kill), saturating at 16'hFFFF.
  - Both counters cleared by reset only.
- Undefined: both ports and counters are absent, with no other behavioural change.

Decomposition:
- Shared package definitions:
  - POISON_WORD = 32'h2A2A_2A2A.
  - skid_state_t enum {EMPTY, BUSY, FULL} (2-bit).
  - CLOCK_PERIOD, used by the bench.
- The state machine and datapath stay in one module; no sub-module.
- Existing fixed stage registers (ifid etc.) may be re-implemented as thin instances with DATA_WIDTH set to their bundle width.

Test Plan:
1. Reset: drive RST_N=0 for 1 cycle with In_Valid=1, In_Data=64'h1 -> next cycle Out_Valid=0, In_Ready=1, Out_Data=64'h2A2A2A2A_2A2A2A2A.
2. Streaming: Out_Ready=1, send 10 consecutive random words -> each appears on Out_Data exactly 1 cycle after in_fire; In_Ready stays 1 throughout.
3. Backpressure:
   - Send A=64'hA, B=64'hB back-to-back with Out_Ready=0 -> Out_Data=A, state FULL, In_Ready=0 next cycle.
   - Raise Out_Ready -> A then B delivered in order; no loss or duplication.
4. Flush while FULL: assert Flush=1 with In_Valid=1, In_Data=64'hC -> next cycle Out_Valid=0, Out_Data=poison; C is never emitted.
5. Reset mid-operation: RST_N=0 while FULL with Out_Ready=0 -> next cycle EMPTY, In_Ready=1, both held words dropped.
6. Perf (PIPE_PERF_EN): hold Out_Ready=0 for 7 cycles with Out_Valid=1, then one flush -> Stall_Count=7, Flush_Count=1; force counters near max -> both saturate, no wrap.
